// File: rtl/lcd_byte_writer.sv
// Write-timing engine for a 4-bit character LCD: sends one byte (or one nibble)
// per valid/ready request with setup, LCD_E pulse, inter-nibble gap and execution wait.
module lcd_byte_writer #(
    parameter int unsigned E_PULSE_CYCLES    = 12,
    parameter int unsigned SETUP_CYCLES      = 2,
    parameter int unsigned NIBBLE_GAP_CYCLES = 50,
    parameter int unsigned CMD_WAIT_CYCLES   = 2000,
    parameter int unsigned CLEAR_WAIT_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_i,
    input  logic       rs_i,
    input  logic       nibble_only_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       done_o,
    output logic       lcd_enabled_o,
    output logic       lcd_register_select_o,
    output logic       lcd_read_write_o,
    output logic       lcd_strataflash_control_o,
    output logic [3:0] lcd_data_o
);

    localparam int unsigned CNT_W = 20;

    // Counter reload values: a state lasting N cycles loads N-1 and leaves at zero.
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(E_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(NIBBLE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP_HI,
        S_PULSE_HI,
        S_GAP,
        S_SETUP_LO,
        S_PULSE_LO,
        S_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             rs_q, rs_d;
    logic             nib_q, nib_d;

    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             e_q, e_d;
    logic             rs_out_q, rs_out_d;
    logic [3:0]       data_q, data_d;

    logic             cnt_zero;
    logic             is_clear;
    logic [CNT_W-1:0] wait_load;

    // Clear Display / Return Home (0x01..0x03 as full commands) need the long wait.
    assign cnt_zero  = (cnt_q == '0);
    assign is_clear  = !rs_q && !nib_q && (byte_q[7:2] == 6'd0) && (byte_q[1:0] != 2'd0);
    assign wait_load = is_clear ? CLEAR_LOAD : CMD_LOAD;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        rs_d    = rs_q;
        nib_d   = nib_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i && ready_q) begin
                    byte_d  = data_i;
                    rs_d    = rs_i;
                    nib_d   = nibble_only_i;
                    state_d = S_SETUP_HI;
                    cnt_d   = SETUP_LOAD;
                end
            end
            S_SETUP_HI: begin
                if (cnt_zero) begin
                    state_d = S_PULSE_HI;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PULSE_HI: begin
                if (cnt_zero) begin
                    if (nib_q) begin
                        state_d = S_WAIT;
                        cnt_d   = wait_load;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    state_d = S_SETUP_LO;
                    cnt_d   = SETUP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SETUP_LO: begin
                if (cnt_zero) begin
                    state_d = S_PULSE_LO;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PULSE_LO: begin
                if (cnt_zero) begin
                    state_d = S_WAIT;
                    cnt_d   = wait_load;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin values are decoded from the next state so they register in step with it.
    always_comb begin
        ready_d  = (state_d == S_IDLE);
        done_d   = (state_q == S_WAIT) && cnt_zero;
        e_d      = (state_d == S_PULSE_HI) || (state_d == S_PULSE_LO);
        rs_out_d = (state_d == S_IDLE) ? 1'b0 : rs_d;
        data_d   = 4'h0;
        case (state_d)
            S_SETUP_HI, S_PULSE_HI, S_GAP: data_d = byte_d[7:4];
            S_SETUP_LO, S_PULSE_LO:        data_d = byte_d[3:0];
            S_WAIT:                        data_d = data_q;
            default:                       data_d = 4'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            byte_q   <= 8'h00;
            rs_q     <= 1'b0;
            nib_q    <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            e_q      <= 1'b0;
            rs_out_q <= 1'b0;
            data_q   <= 4'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            rs_q     <= rs_d;
            nib_q    <= nib_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            e_q      <= e_d;
            rs_out_q <= rs_out_d;
            data_q   <= data_d;
        end
    end

    assign ready_o                   = ready_q;
    assign done_o                    = done_q;
    assign lcd_enabled_o             = e_q;
    assign lcd_register_select_o     = rs_out_q;
    assign lcd_data_o                = data_q;
    assign lcd_read_write_o          = 1'b0;
    assign lcd_strataflash_control_o = 1'b1;

endmodule

// File: doc/lcd_byte_writer.md
# lcd_byte_writer

Write-timing engine for the 4-bit character LCD interface. It accepts one command or data byte at a time from the LCD control sequencer over a valid/ready handshake. It drives the LCD pins with two nibble writes (upper then lower), generating setup, the LCD_E pulse, the inter-nibble gap and the post-byte execution wait. It sits between the sequencer and the LCD pins. A nibble-only mode covers the power-on init writes (0x3, 0x3, 0x3, 0x2).

## Interface
- E_PULSE_CYCLES, 12, LCD_E high time in clocks (240 ns at 50 MHz)
- SETUP_CYCLES, 2, RS/data stable before LCD_E rises
- NIBBLE_GAP_CYCLES, 50, clocks from LCD_E fall of upper nibble to start of lower-nibble setup (1 us)
- CMD_WAIT_CYCLES, 2000, post-byte wait for normal command/data (40 us)
- CLEAR_WAIT_CYCLES, 82000, post-byte wait for Clear Display / Return Home (1.64 ms)
- Clock  in  1  system clock, 50 MHz, rising edge
- Reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- iData  in  8  byte to write; only iData[7:4] used in nibble-only mode
- iRS  in  1  0 = command, 1 = data
- iNibbleOnly  in  1  1 = write iData[7:4] only, skip lower nibble
- iValid  in  1  request valid
- oReady  out  1  block idle and able to accept
- oDone  out  1  one-cycle pulse when a transfer, including its wait, completes
- oLCD_Enabled  out  1  LCD_E
- oLCD_RegisterSelect  out  1  LCD_RS
- oLCD_ReadWrite  out  1  constant 0 (write only)
- oLCD_StrataFlashControl  out  1  constant 1 (StrataFlash disabled)
- oLCD_Data  out  4  LCD data nibble

## Operation
- All outputs except the two constants are registered.
- Reset values: oReady=0, oDone=0, oLCD_Enabled=0, oLCD_RegisterSelect=0, oLCD_Data=0, state IDLE, counter 0.
- oReady=1 from the first clock after Reset deasserts, whenever in IDLE.
- Accept occurs on a rising edge with iValid=1 and oReady=1.
  - iData, iRS and iNibbleOnly are latched at accept and ignored afterwards.
  - oReady drops the next cycle.
  - iValid while busy is ignored; upstream holds its request.
- States and transitions:
  - IDLE: E=0, data=0, RS=0. On accept, go to SETUP_HI.
  - SETUP_HI: data=iData[7:4], RS latched, E=0, for SETUP_CYCLES. Then go to PULSE_HI.
  - PULSE_HI: E=1 for E_PULSE_CYCLES. Then go to WAIT if nibble-only, otherwise GAP.
  - GAP: E=0, upper nibble and RS held, for NIBBLE_GAP_CYCLES. Then go to SETUP_LO.
  - SETUP_LO: data=iData[3:0], for SETUP_CYCLES. Then go to PULSE_LO.
  - PULSE_LO: E=1 for E_PULSE_CYCLES. Then go to WAIT.
  - WAIT: E=0, data and RS held. Length is CLEAR_WAIT_CYCLES if RS=0, not nibble-only and byte ∈ {0x01, 0x02, 0x03}; otherwise CMD_WAIT_CYCLES. Then go to IDLE with oDone=1 and oReady=1 in that same first IDLE cycle.
- The single down-counter reloads on every state entry; width is 20 bits.
- Parameters larger than 2^20−1 are unsupported.
- Reset asserted mid-transfer:
  - Outputs go to reset values asynchronously.
  - The transfer is abandoned with no oDone.
  - The LCD may see a truncated E pulse; the sequencer re-runs init.
- Back-to-back: a new accept may occur in the same cycle oDone is high.

## Timing
- Accept edge = cycle 0. The cycles below are the cycles after the edge in which the outputs hold the stated values.
- Full byte, normal wait:
  - setup: cycles 1–2
  - E high: 3–14
  - gap: 15–64
  - setup: 65–66
  - E high: 67–78
  - wait: 79–2078
  - oDone and oReady: cycle 2079
- Full byte, clear wait: same as above to cycle 78; wait 79–82078; oDone at cycle 82079.
- Nibble-only: setup 1–2, E high 3–14, wait 15–2014, oDone at cycle 2015.
- Data and RS are stable from ≥2 cycles before each E rise until ≥50 cycles after each E fall. They never change while E=1.
- E is never high for more or fewer than E_PULSE_CYCLES consecutive cycles.

## Test plan
- Reset release then 0x28 command, RS=0:
  - oReady=1 from the first cycle after release.
  - E high in cycles 3–14 with data 0x2, and cycles 67–78 with data 0x8.
  - oDone pulse at cycle 2079.
- Nibble-only 0x30, RS=0: single E pulse in cycles 3–14 with data 0x3, no second pulse, oDone at cycle 2015.
- Clear 0x01, RS=0: oDone at cycle 82079. Data byte 0x01 with RS=1 gives oDone at cycle 2079.
- Data 0x41, RS=1, with iValid held high continuously:
  - Exactly one transfer per oDone.
  - The next transfer is accepted in the oDone cycle, and its E first rises 3 cycles later.
- Change iData/iRS every cycle after accept: pin values still reflect the latched byte.
- Assert Reset in cycle 10 (E high): E, RS and data go to 0 immediately, and there is no oDone. After release, a new 0x0C transfer completes normally.
